// File: rtl/alarm_scheduler_pkg.sv
// rtl/alarm_scheduler_pkg.sv - shared encodings, constants and helpers for the alarm scheduler
package alarm_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_ONCE   = 2'b01,
        MODE_DAILY  = 2'b10,
        MODE_WEEKLY = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    localparam int unsigned SEC_PER_DAY  = 86400;
    localparam int unsigned SEC_PER_WEEK = 604800;

    function automatic logic [7:0] bcd2bin8(input logic [7:0] b);
        return {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
    endfunction

    function automatic logic [13:0] bcd2bin16(input logic [15:0] b);
        return {10'd0, b[15:12]} * 14'd1000 + {10'd0, b[11:8]} * 14'd100
             + {10'd0, b[7:4]} * 14'd10 + {10'd0, b[3:0]};
    endfunction

    // Days in the (non-leap) year preceding the first of month m.
    function automatic logic [8:0] days_before_month(input logic [7:0] m);
        case (m)
            8'd2:    return 9'd31;
            8'd3:    return 9'd59;
            8'd4:    return 9'd90;
            8'd5:    return 9'd120;
            8'd6:    return 9'd151;
            8'd7:    return 9'd181;
            8'd8:    return 9'd212;
            8'd9:    return 9'd243;
            8'd10:   return 9'd273;
            8'd11:   return 9'd304;
            8'd12:   return 9'd334;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] period_of(input mode_e m);
        return (m == MODE_WEEKLY) ? SEC_PER_WEEK : SEC_PER_DAY;
    endfunction

endpackage

// File: rtl/alarm_scheduler_time2stamp.sv
// rtl/alarm_scheduler_time2stamp.sv - combinational BCD calendar time to seconds since 1970-01-01 00:00:00
// Ports: year_bcd..second_bcd in (BCD date/time), stamp out (STAMP_W seconds).
module time2stamp
    import alarm_scheduler_pkg::*;
#(
    parameter int STAMP_W = 64
) (
    input  logic [15:0]        year_bcd,
    input  logic [7:0]         month_bcd,
    input  logic [7:0]         day_bcd,
    input  logic [7:0]         hour_bcd,
    input  logic [7:0]         minute_bcd,
    input  logic [7:0]         second_bcd,
    output logic [STAMP_W-1:0] stamp
);
    logic [13:0] year;
    logic [13:0] year_m1;
    logic [7:0]  month, day, hour, minute, second;
    logic        leap_year;
    logic [31:0] leaps;
    logic [31:0] days;

    always_comb begin
        year    = bcd2bin16(year_bcd);
        month   = bcd2bin8(month_bcd);
        day     = bcd2bin8(day_bcd);
        hour    = bcd2bin8(hour_bcd);
        minute  = bcd2bin8(minute_bcd);
        second  = bcd2bin8(second_bcd);
        year_m1 = year - 14'd1;
        // Leap days in [1970, year): leap count up to year-1 minus the 477 up to 1969.
        leaps = 32'(year_m1 / 14'd4) - 32'(year_m1 / 14'd100) + 32'(year_m1 / 14'd400) - 32'd477;
        leap_year = ((year % 14'd4) == 14'd0) &&
                    (((year % 14'd100) != 14'd0) || ((year % 14'd400) == 14'd0));
        days = 32'(year - 14'd1970) * 32'd365 + leaps + 32'(days_before_month(month))
             + ((leap_year && (month > 8'd2)) ? 32'd1 : 32'd0) + 32'(day) - 32'd1;
        stamp = STAMP_W'(days) * STAMP_W'(SEC_PER_DAY) + STAMP_W'(hour) * STAMP_W'(3600)
              + STAMP_W'(minute) * STAMP_W'(60) + STAMP_W'(second);
    end

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-channel alarm scheduler with calendar configuration, roll-forward and snooze
// Ports: cfg_valid/cfg_ready/cfg_idx/cfg_mode + BCD time (configuration), counter (current seconds),
//        ack/snooze (per-channel dismiss), cfg_err (roll-forward overflow pulse), fire/ringing/armed (per channel).
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STAMP_W    = 64,
    parameter int SNOOZE_SEC = 300,
    parameter int ADJ_MAX    = 16,
    parameter int IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_mode,
    input  logic [15:0]        year_bcd,
    input  logic [7:0]         month_bcd,
    input  logic [7:0]         day_bcd,
    input  logic [7:0]         hour_bcd,
    input  logic [7:0]         minute_bcd,
    input  logic [7:0]         second_bcd,
    input  logic [STAMP_W-1:0] counter,
    input  logic [N_CH-1:0]    ack,
    input  logic [N_CH-1:0]    snooze,
    output logic               cfg_err,
    output logic [N_CH-1:0]    fire,
    output logic [N_CH-1:0]    ringing,
    output logic [N_CH-1:0]    armed
);
    state_e              state, state_next;
    logic [IDX_W-1:0]    idx_q;
    mode_e               mode_q;
    logic [15:0]         year_q;
    logic [7:0]          month_q, day_q, hour_q, minute_q, second_q;
    logic [STAMP_W-1:0]  conv_stamp, work_stamp, period;
    logic [15:0]         adj_cnt, adj_limit;
    logic                due, overflow, commit_en;
    mode_e               commit_mode;

    logic [STAMP_W-1:0]  stamp_r   [N_CH];
    logic [STAMP_W-1:0]  snz_stamp [N_CH];
    mode_e               mode_r    [N_CH];
    logic [N_CH-1:0]     snz_act;

    time2stamp #(.STAMP_W(STAMP_W)) u_time2stamp (
        .year_bcd   (year_q),
        .month_bcd  (month_q),
        .day_bcd    (day_q),
        .hour_bcd   (hour_q),
        .minute_bcd (minute_q),
        .second_bcd (second_q),
        .stamp      (conv_stamp)
    );

    assign period    = STAMP_W'(period_of(mode_q));
    assign adj_limit = (mode_q == MODE_ONCE) ? 16'd1 : 16'(ADJ_MAX);
    assign due       = (work_stamp <= counter);
    assign cfg_ready = (state == ST_IDLE);
    // An overflow writes the channel as OFF through the same commit path.
    assign commit_en   = (state == ST_COMMIT) || overflow;
    assign commit_mode = overflow ? MODE_OFF : mode_q;

    always_comb begin
        state_next = state;
        overflow   = 1'b0;
        case (state)
            ST_IDLE:    if (cfg_valid)
                            state_next = (mode_e'(cfg_mode) == MODE_OFF) ? ST_COMMIT : ST_CONVERT;
            ST_CONVERT: state_next = ST_ADJUST;
            ST_ADJUST: begin
                if (!due) begin
                    state_next = ST_COMMIT;
                end else if (adj_cnt >= adj_limit) begin
                    overflow   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cfg_err    <= 1'b0;
            idx_q      <= '0;
            mode_q     <= MODE_OFF;
            year_q     <= '0;
            month_q    <= '0;
            day_q      <= '0;
            hour_q     <= '0;
            minute_q   <= '0;
            second_q   <= '0;
            work_stamp <= '0;
            adj_cnt    <= '0;
        end else begin
            state   <= state_next;
            cfg_err <= overflow;
            case (state)
                ST_IDLE: if (cfg_valid) begin
                    idx_q    <= cfg_idx;
                    mode_q   <= mode_e'(cfg_mode);
                    year_q   <= year_bcd;
                    month_q  <= month_bcd;
                    day_q    <= day_bcd;
                    hour_q   <= hour_bcd;
                    minute_q <= minute_bcd;
                    second_q <= second_bcd;
                    adj_cnt  <= '0;
                end
                ST_CONVERT: work_stamp <= conv_stamp;
                ST_ADJUST: if (due && !overflow) begin
                    work_stamp <= work_stamp + period;
                    adj_cnt    <= adj_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit_main, hit_snz, commit_here;

        assign commit_here = commit_en && (idx_q == IDX_W'(i));
        assign hit_main    = armed[i] && (counter >= stamp_r[i]);
        assign hit_snz     = snz_act[i] && (counter >= snz_stamp[i]);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stamp_r[i]   <= '0;
                snz_stamp[i] <= '0;
                mode_r[i]    <= MODE_OFF;
                snz_act[i]   <= 1'b0;
                armed[i]     <= 1'b0;
                ringing[i]   <= 1'b0;
                fire[i]      <= 1'b0;
            end else if (commit_here) begin
                // Configuration wins over a coincident match on this channel.
                stamp_r[i]   <= work_stamp;
                mode_r[i]    <= commit_mode;
                snz_act[i]   <= 1'b0;
                armed[i]     <= (commit_mode != MODE_OFF);
                ringing[i]   <= 1'b0;
                fire[i]      <= 1'b0;
            end else begin
                fire[i] <= (hit_main || hit_snz) && !ringing[i];
                if (hit_snz)
                    snz_act[i] <= 1'b0;
                if (hit_main) begin
                    case (mode_r[i])
                        MODE_ONCE:   armed[i]   <= 1'b0;
                        MODE_DAILY:  stamp_r[i] <= stamp_r[i] + STAMP_W'(SEC_PER_DAY);
                        MODE_WEEKLY: stamp_r[i] <= stamp_r[i] + STAMP_W'(SEC_PER_WEEK);
                        default:     armed[i]   <= 1'b0;
                    endcase
                end
                if (hit_main || hit_snz)
                    ringing[i] <= 1'b1;
                // Dismissal only acts on a ringing channel; ack beats snooze.
                if (ringing[i] && ack[i]) begin
                    ringing[i] <= 1'b0;
                end else if (ringing[i] && snooze[i]) begin
                    ringing[i]   <= 1'b0;
                    snz_act[i]   <= 1'b1;
                    snz_stamp[i] <= counter + STAMP_W'(SNOOZE_SEC);
                end
            end
        end
    end

endmodule
